// File: rtl/tpg_pkg.sv
// Shared constants for the multi-mode test pattern generator.
// Mode encodings and a constant-evaluable clog2 helper.
package tpg_pkg;

  localparam logic [2:0] MODE_BARS  = 3'd0;
  localparam logic [2:0] MODE_GRAY  = 3'd1;
  localparam logic [2:0] MODE_CHECK = 3'd2;
  localparam logic [2:0] MODE_BOX   = 3'd3;
  localparam logic [2:0] MODE_GRID  = 3'd4;
  localparam logic [2:0] MODE_RED   = 3'd5;
  localparam logic [2:0] MODE_GREEN = 3'd6;
  localparam logic [2:0] MODE_BLUE  = 3'd7;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tpg_box_anim.sv
// Bouncing box position: x/y registers plus direction flags, stepped once per frame tick.
// Ports: clk, rst_n (async, active-low), tick in; box_x/box_y out (top-left corner).
module tpg_box_anim
  import tpg_pkg::*;
#(
  parameter int WIDTH    = 1024,
  parameter int HEIGHT   = 768,
  parameter int BOX_SIZE = 64,
  parameter int BOX_STEP = 2,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  output logic [XW-1:0] box_x,
  output logic [YW-1:0] box_y
);

  localparam int X_MAX = WIDTH - BOX_SIZE;
  localparam int Y_MAX = HEIGHT - BOX_SIZE;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          dx_q, dx_d;
  logic          dy_q, dy_d;
  int            nx, ny;
  logic          ndx, ndy;

  // fwd=1 means moving right/down; clamp to the edge and reverse on overshoot
  function automatic void bounce(
    input  int   pos,
    input  logic fwd,
    input  int   hi,
    output int   npos,
    output logic nfwd
  );
    npos = pos;
    nfwd = fwd;
    if (fwd) begin
      if (pos + BOX_STEP > hi) begin
        npos = hi;
        nfwd = 1'b0;
      end else begin
        npos = pos + BOX_STEP;
      end
    end else if (pos < BOX_STEP) begin
      npos = 0;
      nfwd = 1'b1;
    end else begin
      npos = pos - BOX_STEP;
    end
  endfunction

  always_comb begin
    nx  = 0;
    ny  = 0;
    ndx = 1'b1;
    ndy = 1'b1;
    bounce(int'(x_q), dx_q, X_MAX, nx, ndx);
    bounce(int'(y_q), dy_q, Y_MAX, ny, ndy);
    x_d  = tick ? XW'(nx) : x_q;
    y_d  = tick ? YW'(ny) : y_q;
    dx_d = tick ? ndx : dx_q;
    dy_d = tick ? ndy : dy_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign box_x = x_q;
  assign box_y = y_q;

endmodule

// File: rtl/tpg_multipattern.sv
// Eight-mode test pattern generator, 2-cycle registered colour from VGA counters.
// Ports: clk, rst_n, ctr_h, ctr_v, mode_sel in; vga_r/g/b, mode_active, frame_cnt out.
module tpg_multipattern
  import tpg_pkg::*;
#(
  parameter int WIDTH       = 1024,
  parameter int HEIGHT      = 768,
  parameter int COLOR_DEPTH = 8,
  parameter int H_BITS      = 11,
  parameter int V_BITS      = 10,
  parameter int BAR_COUNT   = 8,
  parameter int CHECK_LOG2  = 5,
  parameter int BOX_SIZE    = 64,
  parameter int BOX_STEP    = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [H_BITS-1:0]      ctr_h,
  input  logic [V_BITS-1:0]      ctr_v,
  input  logic [2:0]             mode_sel,
  output logic [COLOR_DEPTH-1:0] vga_r,
  output logic [COLOR_DEPTH-1:0] vga_g,
  output logic [COLOR_DEPTH-1:0] vga_b,
  output logic [2:0]             mode_active,
  output logic [15:0]            frame_cnt
);

  localparam int CW         = COLOR_DEPTH;
  localparam int PW         = H_BITS + V_BITS;
  localparam int BAR_SHIFT  = clog2(WIDTH / BAR_COUNT);
  localparam int GRAY_SHIFT = clog2(WIDTH) - COLOR_DEPTH;
  localparam logic [CW-1:0] FS   = '1;
  localparam logic [CW-1:0] BG_B = {2'b01, {(CW-2){1'b0}}};

  logic [PW-1:0]     prev_q, prev_d;
  logic [H_BITS-1:0] h1_q, h1_d;
  logic [V_BITS-1:0] v1_q, v1_d;
  logic              blank1_q, blank1_d;
  logic [2:0]        mode_q, mode_d;
  logic [15:0]       frame_q, frame_d;
  logic [CW-1:0]     r_q, r_d;
  logic [CW-1:0]     g_q, g_d;
  logic [CW-1:0]     b_q, b_d;
  logic              tick;
  logic [H_BITS-1:0] box_x;
  logic [V_BITS-1:0] box_y;

  // prev resets to all-ones so the first origin after reset ticks
  assign tick = (ctr_h == '0) && (ctr_v == '0) && (prev_q != '0);

  always_comb begin
    prev_d   = {ctr_h, ctr_v};
    h1_d     = ctr_h;
    v1_d     = ctr_v;
    blank1_d = ({1'b0, ctr_h} >= (H_BITS + 1)'(WIDTH))
            || ({1'b0, ctr_v} >= (V_BITS + 1)'(HEIGHT));
    mode_d   = tick ? mode_sel : mode_q;
    frame_d  = tick ? frame_q + 16'd1 : frame_q;
  end

  tpg_box_anim #(
    .WIDTH    (WIDTH),
    .HEIGHT   (HEIGHT),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP),
    .XW       (H_BITS),
    .YW       (V_BITS)
  ) u_box (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .box_x (box_x),
    .box_y (box_y)
  );

  logic [2:0]    bar;
  logic [CW-1:0] gray;
  logic          in_box;
  logic          on_grid;
  logic          chk;

  assign bar  = 3'(h1_q >> BAR_SHIFT);
  assign gray = CW'(h1_q >> GRAY_SHIFT);
  assign chk  = h1_q[CHECK_LOG2] ^ v1_q[CHECK_LOG2];

  assign in_box = (int'(h1_q) >= int'(box_x))
               && (int'(h1_q) < int'(box_x) + BOX_SIZE)
               && (int'(v1_q) >= int'(box_y))
               && (int'(v1_q) < int'(box_y) + BOX_SIZE);

  assign on_grid = (h1_q == '0)
                || (h1_q == H_BITS'(WIDTH - 1))
                || (h1_q == H_BITS'(WIDTH / 2))
                || (v1_q == '0)
                || (v1_q == V_BITS'(HEIGHT - 1))
                || (v1_q == V_BITS'(HEIGHT / 2));

  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!blank1_q) begin
      unique case (mode_q)
        MODE_BARS: begin
          r_d = {CW{bar[0]}};
          g_d = {CW{bar[1]}};
          b_d = {CW{bar[2]}};
        end
        MODE_GRAY: begin
          r_d = gray;
          g_d = gray;
          b_d = gray;
        end
        MODE_CHECK: begin
          r_d = {CW{chk}};
          g_d = {CW{chk}};
          b_d = {CW{chk}};
        end
        MODE_BOX: begin
          r_d = in_box ? FS : '0;
          g_d = in_box ? FS : '0;
          b_d = in_box ? FS : BG_B;
        end
        MODE_GRID: begin
          r_d = {CW{on_grid}};
          g_d = {CW{on_grid}};
          b_d = {CW{on_grid}};
        end
        MODE_RED:   r_d = FS;
        MODE_GREEN: g_d = FS;
        MODE_BLUE:  b_d = FS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '1;
      h1_q     <= '0;
      v1_q     <= '0;
      blank1_q <= 1'b0;
      mode_q   <= '0;
      frame_q  <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      prev_q   <= prev_d;
      h1_q     <= h1_d;
      v1_q     <= v1_d;
      blank1_q <= blank1_d;
      mode_q   <= mode_d;
      frame_q  <= frame_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign mode_active = mode_q;
  assign frame_cnt   = frame_q;

endmodule

// File: tb/tb_tpg_multipattern.sv
// Directed bench for tpg_multipattern with a pixel scoreboard.
// Expected colours come from an independent pattern/box model.
module tb_tpg_multipattern;

  localparam int W  = 1024;
  localparam int H  = 768;
  localparam int BS = 64;
  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ctr_h = '0;
  logic [9:0]  ctr_v = '0;
  logic [2:0]  mode_sel = '0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic [2:0]  mode_active;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [23:0] rgb;
    string       tag;
  } exp_t;

  exp_t q[$];

  int m_mode, m_frame, m_bx, m_by, m_ph, m_pv;
  bit m_dx, m_dy;

  always #5 clk = ~clk;

  tpg_multipattern dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ctr_h       (ctr_h),
    .ctr_v       (ctr_v),
    .mode_sel    (mode_sel),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .mode_active (mode_active),
    .frame_cnt   (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_frame = 0; m_bx = 0; m_by = 0;
    m_dx = 1; m_dy = 1; m_ph = -1; m_pv = -1;
    q.delete();
  endtask

  task automatic adv(inout int p, inout bit fwd, input int lim);
    if (fwd) begin
      if (p + ST > lim - BS) begin p = lim - BS; fwd = 0; end
      else p = p + ST;
    end else begin
      if (p < ST) begin p = 0; fwd = 1; end
      else p = p - ST;
    end
  endtask

  function automatic logic [23:0] exp_rgb(int h, int v, int md, int bx, int by);
    logic [2:0] i;
    logic [7:0] g;
    if (h >= W || v >= H) return 24'h0;
    case (md)
      0: begin
        i = 3'(h / 128);
        return {i[0] ? 8'hFF : 8'h00, i[1] ? 8'hFF : 8'h00, i[2] ? 8'hFF : 8'h00};
      end
      1: begin
        g = 8'(h / 4);
        return {g, g, g};
      end
      2: return ((((h / 32) + (v / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      3: return (h >= bx && h < bx + BS && v >= by && v < by + BS)
                ? 24'hFFFFFF : 24'h000040;
      4: return (h == 0 || h == W - 1 || h == W / 2 ||
                 v == 0 || v == H - 1 || v == H / 2) ? 24'hFFFFFF : 24'h0;
      5: return 24'hFF0000;
      6: return 24'h00FF00;
      default: return 24'h0000FF;
    endcase
  endfunction

  task automatic step(input int h, input int v, input logic chk, input string tag);
    exp_t e;
    ctr_h = 11'(h);
    ctr_v = 10'(v);
    if (h == 0 && v == 0 && !(m_ph == 0 && m_pv == 0)) begin
      m_mode = int'(mode_sel);
      m_frame = (m_frame + 1) & 16'hFFFF;
      adv(m_bx, m_dx, W);
      adv(m_by, m_dy, H);
    end
    m_ph = h;
    m_pv = v;
    e.chk = chk;
    e.rgb = exp_rgb(h, v, m_mode, m_bx, m_by);
    e.tag = tag;
    q.push_back(e);
    @(posedge clk);
    #1;
    check({tag, "_frame"}, 32'(frame_cnt), 32'(m_frame));
    check({tag, "_mode"}, 32'(mode_active), 32'(m_mode));
    if (q.size() == 2) begin
      e = q.pop_front();
      if (e.chk) check(e.tag, 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
    end
  endtask

  int hs[10] = '{4, 32, 40, 512, 3, 1023, 5, 1100, 5, 130};
  int vs[10] = '{5, 5, 40, 3, 384, 767, 767, 5, 800, 9};
  int f0;

  initial begin
    model_reset();
    #1;
    check("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("rst_frame", 32'(frame_cnt), 32'h0);
    check("rst_mode", 32'(mode_active), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // colour bars across one line
    mode_sel = 3'd0;
    step(1, 1, 0, "pre");
    step(0, 0, 1, "bar_org");
    for (int i = 0; i < 8; i++) step(i * 128, 10, 1, $sformatf("bar%0d", i));
    step(1, 1, 0, "pad");

    // explicit gray values
    mode_sel = 3'd1;
    step(0, 0, 1, "gray_org");
    step(4, 5, 1, "gray4");
    step(1023, 5, 1, "gray1023");
    step(1, 1, 0, "pad");
    check("gray_mode", 32'(mode_active), 32'd1);

    // every mode over a common coordinate set incl. blanking
    for (int md = 0; md < 8; md++) begin
      mode_sel = 3'(md);
      step(1, 1, 0, "pad");
      step(0, 0, 1, $sformatf("m%0d_org", md));
      for (int k = 0; k < 10; k++)
        step(hs[k], vs[k], 1, $sformatf("m%0d_%0d_%0d", md, hs[k], vs[k]));
    end
    step(1, 1, 0, "pad");

    // mode change mid-frame waits for next tick
    mode_sel = 3'd0;
    step(0, 0, 1, "mc_org");
    step(640, 299, 1, "mc_a");
    mode_sel = 3'd5;
    step(256, 300, 1, "mc_b");
    step(900, 500, 1, "mc_c");
    check("mc_hold", 32'(mode_active), 32'd0);
    step(0, 0, 1, "mc_tick");
    step(1, 1, 0, "pad");
    check("mc_new", 32'(mode_active), 32'd5);

    // held origin ticks once
    f0 = int'(frame_cnt);
    for (int i = 0; i < 5; i++) step(0, 0, 1, "hold");
    step(1, 1, 0, "pad");
    check("hold_once", 32'(frame_cnt), 32'((f0 + 1) & 16'hFFFF));

    // frame counter wrap
    force dut.frame_q = 16'hFFFF;
    #1;
    release dut.frame_q;
    m_frame = 16'hFFFF;
    step(2, 2, 0, "pre_wrap");
    check("preload", 32'(frame_cnt), 32'hFFFF);
    step(0, 0, 1, "wrap");
    check("wrapped", 32'(frame_cnt), 32'h0);
    step(1, 1, 0, "pad");

    // run box to x=100 then reset mid-line
    mode_sel = 3'd3;
    for (int n = 0; n < 1000 && m_bx != 100; n++) begin
      step(0, 0, 0, "run");
      step(1, 1, 0, "run");
    end
    step(m_bx, m_by, 1, "pre_rst_box");
    step(1, 1, 0, "pad");
    step(m_bx, m_by, 0, "lastwhite");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
    check("arst_frame", 32'(frame_cnt), 32'h0);
    check("arst_mode", 32'(mode_active), 32'h0);
    model_reset();
    ctr_h = '0;
    ctr_v = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 1, "rel_org");
    check("rel_frame1", 32'(frame_cnt), 32'd1);
    step(2, 2, 1, "rel_box_in");
    step(1, 2, 1, "rel_box_out");

    // bouncing box over 600 frames total
    for (int f = 1; f < 600; f++) begin
      step(0, 0, 1, "bx_org");
      step(m_bx, m_by, 1, "bx_tl");
      step(m_bx > 0 ? m_bx - 1 : m_bx + BS, m_by, 1, "bx_left");
      step(m_bx + BS - 1, m_by + BS - 1, 1, "bx_br");
      step(m_bx, m_by + BS, 1, "bx_below");
    end
    step(1, 1, 0, "pad");
    step(1, 1, 0, "pad");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
